// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and size defaults for the pipe stage buffer
package pipe_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LANES_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t EMPTY = 2'd0;
  localparam state_t BUSY  = 2'd1;
  localparam state_t FULL  = 2'd2;

endpackage

// File: rtl/pipe_stage_buf_reg.sv
// rtl/pipe_stage_buf_reg.sv - wide data register with load enable and synchronous clear
module pipe_stage_buf_reg #(
  parameter int DW = 256
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge Clk) begin
    if (!Rst_n || clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid buffer stage; head register drives out_data directly
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [1:0]             out_count
);

  localparam int DW = LANES * WIDTH;

  state_t          state;
  state_t          state_nxt;
  logic            in_xfer;
  logic            out_xfer;
  logic            main_ld;
  logic            main_clr;
  logic            main_sel_skid;
  logic            skid_ld;
  logic            skid_clr;
  logic [DW-1:0]   main_d;
  logic [DW-1:0]   main_q;
  logic [DW-1:0]   skid_q;

  // Handshake flags depend only on the state register, never on in_valid
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_count = state;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge Clk) begin
    if (!Rst_n || flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_xfer) state_nxt = BUSY;
      BUSY: begin
        if (in_xfer && !out_xfer)      state_nxt = FULL;
        else if (!in_xfer && out_xfer) state_nxt = EMPTY;
      end
      FULL:    if (out_xfer) state_nxt = BUSY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Head is cleared when it drains so an idle stage presents the all-zero NOP
  always_comb begin
    main_ld       = 1'b0;
    main_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    main_clr      = flush;
    skid_clr      = flush;
    case (state)
      EMPTY: main_ld = in_xfer;
      BUSY: begin
        main_ld  = in_xfer & out_xfer;
        skid_ld  = in_xfer & ~out_xfer;
        main_clr = flush | (out_xfer & ~in_xfer);
      end
      FULL: begin
        main_ld       = out_xfer;
        main_sel_skid = 1'b1;
        skid_clr      = flush | out_xfer;
      end
      default: begin
        main_clr = 1'b1;
        skid_clr = 1'b1;
      end
    endcase
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  pipe_stage_buf_reg #(.DW(DW)) u_main (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (main_clr),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_stage_buf_reg #(.DW(DW)) u_skid (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (skid_clr),
    .load  (skid_ld),
    .d     (in_data),
    .q     (skid_q)
  );

  assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed checks on an 8x32 stage plus a scoreboarded 3x7 random run
module tb_pipe_stage_buf;

  logic         Clk;
  logic         Rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [1:0]   out_count;

  logic         b_flush;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [20:0]  b_in_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [20:0]  b_out_data;
  logic [1:0]   b_out_count;

  int errors = 0;
  int checks = 0;

  logic [20:0] sb_q[$];
  logic [20:0] sb_exp;

  pipe_stage_buf dut (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  pipe_stage_buf #(.WIDTH(7), .LANES(3)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_count(b_out_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = {32{8'hAA}};
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

    // Reset held with a valid beat on the input
    step(); step();
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_out_data",  out_data,        256'd0);
    chk("rst_in_ready",  256'(in_ready),  256'd1);
    chk("rst_out_count", 256'(out_count), 256'd0);
    chk("rst_b_valid",   256'(b_out_valid), 256'd0);

    Rst_n = 1'b1; in_valid = 1'b0;
    step();
    chk("idle_out_valid", 256'(out_valid), 256'd0);

    // Streaming: each beat visible one edge after acceptance
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 256'(i);
      chk("stream_in_ready", 256'(in_ready), 256'd1);
      step();
      chk("stream_data",  out_data,        256'(i));
      chk("stream_count", 256'(out_count), 256'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_valid", 256'(out_valid), 256'd0);
    chk("stream_drain_data",  out_data,        256'd0);

    // Backpressure: A, B fill the stage, C is held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 256'hA1;
    step();
    chk("bp_count1", 256'(out_count), 256'd1);
    in_data = 256'hB2;
    step();
    chk("bp_count2",   256'(out_count), 256'd2);
    chk("bp_in_ready", 256'(in_ready),  256'd0);
    chk("bp_head_a",   out_data,        256'hA1);
    in_data = 256'hC3;
    step();
    chk("bp_hold_count", 256'(out_count), 256'd2);
    chk("bp_hold_a",     out_data,        256'hA1);
    out_ready = 1'b1;
    step();
    chk("bp_head_b",  out_data,        256'hB2);
    chk("bp_count_b", 256'(out_count), 256'd1);
    step();
    chk("bp_head_c",  out_data,        256'hC3);
    in_valid = 1'b0;
    step();
    chk("bp_empty", 256'(out_valid), 256'd0);

    // Flush while FULL; D offered in the flush cycle must never appear
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 256'hA1;
    step();
    in_data = 256'hB2;
    step();
    chk("fl_full", 256'(out_count), 256'd2);
    flush = 1'b1; in_data = 256'hD4;
    step();
    chk("fl_out_valid", 256'(out_valid), 256'd0);
    chk("fl_out_data",  out_data,        256'd0);
    chk("fl_out_count", 256'(out_count), 256'd0);
    chk("fl_in_ready",  256'(in_ready),  256'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_d", 256'(out_valid), 256'd0);

    // Flush coinciding with out transfer and an accepted in beat in BUSY
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 256'h55;
    step();
    flush = 1'b1; out_ready = 1'b1; in_data = 256'h66;
    step();
    chk("flo_count", 256'(out_count), 256'd0);
    chk("flo_data",  out_data,        256'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flo_still_empty", 256'(out_valid), 256'd0);

    // One-cycle reset in BUSY, then E emerges alone
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 256'h77;
    step();
    Rst_n = 1'b0; in_valid = 1'b0;
    step();
    chk("mr_count", 256'(out_count), 256'd0);
    chk("mr_data",  out_data,        256'd0);
    Rst_n = 1'b1;
    step();
    chk("mr_after_valid", 256'(out_valid), 256'd0);
    in_valid = 1'b1; in_data = 256'hE5;
    step();
    chk("mr_e_data",  out_data,        256'hE5);
    chk("mr_e_count", 256'(out_count), 256'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("mr_e_alone", 256'(out_valid), 256'd0);

    // Random valid/ready on the 3x7 instance against a queue model
    for (int c = 0; c < 10000; c++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_in_data   = 21'($urandom);
      #1;
      chk("rnd_count", 256'(b_out_count), 256'(sb_q.size()));
      if (b_out_valid && b_out_ready) begin
        sb_exp = (sb_q.size() != 0) ? sb_q.pop_front() : 21'bx;
        chk("rnd_data", 256'(b_out_data), 256'(sb_exp));
      end
      if (b_in_valid && b_in_ready) sb_q.push_back(b_in_data);
      step();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    for (int c = 0; c < 4 && sb_q.size() != 0; c++) begin
      #1;
      if (b_out_valid) begin
        sb_exp = sb_q.pop_front();
        chk("drain_data", 256'(b_out_data), 256'(sb_exp));
      end
      step();
    end
    chk("drain_left", 256'(sb_q.size()), 256'd0);
    chk("drain_valid", 256'(b_out_valid), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
